// File: rtl/mnist_pkg.sv
// mnist_pkg: shared logit/layer dimensions and the inference FSM state encoding
package mnist_pkg;
  localparam int LOGIT_W = 32;
  localparam int N_CLASSES = 10;
  localparam int FC1_IN = 784;
  localparam int FC1_OUT = 32;
  localparam int FC2_IN = FC1_OUT;
  localparam int FC2_OUT = N_CLASSES;
  typedef enum logic [2:0] {S_IDLE, S_FC1, S_FC2, S_ARG, S_DONE, S_ABORT} state_t;
endpackage

// File: rtl/mnist_infer_sequencer_if.sv
// mnist_infer_sequencer_if: fc1/fc2 start-done pulses and the 1-cycle logit read port (master = sequencer, slave = layers/logit memory)
interface mnist_infer_sequencer_if import mnist_pkg::*; #(parameter int OUT_DIM = N_CLASSES);
  logic fc1_start, fc1_done, fc2_start, fc2_done;
  logic [$clog2(OUT_DIM)-1:0] l_addr;
  logic signed [LOGIT_W-1:0] l_data;
  modport master(output fc1_start, fc2_start, l_addr, input fc1_done, fc2_done, l_data);
  modport slave(input fc1_start, fc2_start, l_addr, output fc1_done, fc2_done, l_data);
endinterface

// File: rtl/argmax_scan.sv
// argmax_scan: on start sweeps l_addr 0..OUT_DIM-1, compares returned logits (signed, strict >) and reports the lowest max index on idx; done marks the last compare
module argmax_scan import mnist_pkg::*; #(
  parameter int OUT_DIM = N_CLASSES,
  localparam int AW = $clog2(OUT_DIM)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done,
  output logic [AW-1:0] l_addr,
  output logic [AW-1:0] idx,
  input  logic signed [LOGIT_W-1:0] l_data
);
  localparam logic [AW-1:0] LAST = AW'(OUT_DIM - 1);
  logic issue, vld;
  logic [AW-1:0] cidx;
  logic signed [LOGIT_W-1:0] best;
  assign done = vld && cidx == LAST;
  always_ff @(posedge clk) begin
    if (rst) begin
      issue <= 1'b0;
      vld <= 1'b0;
      l_addr <= '0;
      cidx <= '0;
      best <= '0;
      idx <= '0;
    end else if (start) begin
      issue <= 1'b1;
      vld <= 1'b0;
      l_addr <= '0;
    end else begin
      issue <= issue && l_addr != LAST;
      vld <= issue;
      cidx <= l_addr;
      if (issue) l_addr <= l_addr == LAST ? '0 : l_addr + 1'b1;
      if (vld && (cidx == '0 || l_data > best)) begin
        best <= l_data;
        idx <= cidx;
      end
    end
  end
endmodule

// File: rtl/mnist_infer_sequencer.sv
// mnist_infer_sequencer: start -> fc1 -> fc2 -> argmax -> done (pred_class, err, cycles), with a per-layer watchdog abort and saturating cycle count
module mnist_infer_sequencer import mnist_pkg::*; #(
  parameter int OUT_DIM = N_CLASSES,
  parameter int TIMEOUT_CYC = 65535,
  parameter int CNT_W = 20,
  localparam int AW = $clog2(OUT_DIM),
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic err,
  output logic [AW-1:0] pred_class,
  output logic [CNT_W-1:0] cycles,
  mnist_infer_sequencer_if.master lb
);
  state_t state;
  logic fc1_start, fc2_start, scan_done, timeout;
  logic [AW-1:0] l_addr, scan_idx;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WD_W-1:0] wd;
  assign lb.fc1_start = fc1_start;
  assign lb.fc2_start = fc2_start;
  assign lb.l_addr = l_addr;
  assign cnt_nxt = &cnt ? cnt : cnt + 1'b1;
  assign timeout = wd == WD_W'(TIMEOUT_CYC - 1);
  argmax_scan #(.OUT_DIM(OUT_DIM)) u_scan (
    .clk(clk),
    .rst(rst),
    .start(state == S_FC2 && lb.fc2_done),
    .done(scan_done),
    .l_addr(l_addr),
    .idx(scan_idx),
    .l_data(lb.l_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      pred_class <= '0;
      cycles <= '0;
      cnt <= '0;
      wd <= '0;
      fc1_start <= 1'b0;
      fc2_start <= 1'b0;
    end else begin
      done <= 1'b0;
      fc1_start <= 1'b0;
      fc2_start <= 1'b0;
      wd <= wd + 1'b1;
      if (busy) cnt <= cnt_nxt;
      case (state)
        S_IDLE: if (start) begin
          state <= S_FC1;
          fc1_start <= 1'b1;
          busy <= 1'b1;
          err <= 1'b0;
          cnt <= '0;
          wd <= '0;
        end
        S_FC1: if (lb.fc1_done) begin
          state <= S_FC2;
          fc2_start <= 1'b1;
          wd <= '0;
        end else if (timeout) state <= S_ABORT;
        S_FC2: state <= lb.fc2_done ? S_ARG : timeout ? S_ABORT : S_FC2;
        S_ARG: if (scan_done) state <= S_DONE;
        S_DONE, S_ABORT: begin
          state <= S_IDLE;
          done <= 1'b1;
          busy <= 1'b0;
          cycles <= cnt_nxt;
          if (state == S_ABORT) err <= 1'b1;
          else pred_class <= scan_idx;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
